// File: rtl/fifo_flags_pkg.sv
// Shared sizing helpers and read-mode constants for the flagged FIFO.
// Imported by the interface, memory and top-level files.
package fifo_pkg;

   typedef enum logic {
      FIFO_NORMAL    = 1'b0,
      FIFO_SHOWAHEAD = 1'b1
   } fifo_mode_e;

   localparam int FIFO_DEFAULT_WIDTH     = 8;
   localparam int FIFO_DEFAULT_DEPTH_BIT = 3;

   function automatic int depth_of(input int depth_bit);
      return 1 << depth_bit;
   endfunction

   // Occupancy must represent DEPTH itself, hence one bit wider than a pointer.
   function automatic int usedw_width(input int depth_bit);
      return depth_bit + 1;
   endfunction

endpackage

// File: rtl/fifo_flags_if.sv
// Producer/consumer side of the flagged FIFO; master drives requests, slave is the FIFO.
interface fifo_flags_if
   import fifo_pkg::*;
#(
   parameter int WIDTH     = FIFO_DEFAULT_WIDTH,
   parameter int DEPTH_BIT = FIFO_DEFAULT_DEPTH_BIT
);

   logic [WIDTH-1:0]   wr_data_i;
   logic               wr_req_i;
   logic               rd_req_i;
   logic [WIDTH-1:0]   rd_data_o;
   logic               full_o;
   logic               empty_o;
   logic               almost_full_o;
   logic               almost_empty_o;
   logic [DEPTH_BIT:0] usedw_o;
   logic               overflow_o;
   logic               underflow_o;

   modport master (
      output wr_data_i, wr_req_i, rd_req_i,
      input  rd_data_o, full_o, empty_o, almost_full_o, almost_empty_o,
             usedw_o, overflow_o, underflow_o
   );

   modport slave (
      input  wr_data_i, wr_req_i, rd_req_i,
      output rd_data_o, full_o, empty_o, almost_full_o, almost_empty_o,
             usedw_o, overflow_o, underflow_o
   );

endinterface

// File: rtl/fifo_flags_mem.sv
// Simple dual-port register array: synchronous write, combinational read.
// Contents are deliberately never reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int WIDTH     = FIFO_DEFAULT_WIDTH,
   parameter int DEPTH_BIT = FIFO_DEFAULT_DEPTH_BIT
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [DEPTH_BIT-1:0] waddr_i,
   input  logic [WIDTH-1:0]     wdata_i,
   input  logic [DEPTH_BIT-1:0] raddr_i,
   output logic [WIDTH-1:0]     rdata_o
);

   localparam int DEPTH = depth_of(DEPTH_BIT);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and optional show-ahead read.
module fifo_flags
   import fifo_pkg::*;
#(
   parameter int WIDTH      = FIFO_DEFAULT_WIDTH,
   parameter int DEPTH_BIT  = FIFO_DEFAULT_DEPTH_BIT,
   parameter int SHOWAHEAD  = int'(FIFO_NORMAL),
   parameter int AFULL_LVL  = depth_of(DEPTH_BIT) - 1,
   parameter int AEMPTY_LVL = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   fifo_flags_if.slave  bus
);

   localparam int               DEPTH    = depth_of(DEPTH_BIT);
   localparam int               UW       = usedw_width(DEPTH_BIT);
   localparam logic [UW-1:0]    DEPTH_U  = UW'(DEPTH);
   localparam logic [UW-1:0]    AFULL_U  = UW'(AFULL_LVL);
   localparam logic [UW-1:0]    AEMPTY_U = UW'(AEMPTY_LVL);

   logic [DEPTH_BIT-1:0] wr_ptr;
   logic [DEPTH_BIT-1:0] rd_ptr;
   logic [UW-1:0]        usedw;
   logic                 full;
   logic                 empty;
   logic                 rd_ok;
   logic                 wr_ok;
   logic                 overflow;
   logic                 underflow;
   logic [WIDTH-1:0]     mem_rdata;

   // Flags come only from the registered count, never from pointer compares.
   assign full  = (usedw == DEPTH_U);
   assign empty = (usedw == '0);

   // A read frees a slot in the same cycle, so a write at full is still taken.
   assign rd_ok = bus.rd_req_i && !empty;
   assign wr_ok = bus.wr_req_i && (!full || bus.rd_req_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         usedw     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   usedw <= usedw + 1'b1;
            2'b01:   usedw <= usedw - 1'b1;
            default: usedw <= usedw;
         endcase
         overflow  <= bus.wr_req_i && !wr_ok;
         underflow <= bus.rd_req_i && !rd_ok;
      end
   end

   fifo_mem #(
      .WIDTH     (WIDTH),
      .DEPTH_BIT (DEPTH_BIT)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (wr_ok && !rst_i),
      .waddr_i (wr_ptr),
      .wdata_i (bus.wr_data_i),
      .raddr_i (rd_ptr),
      .rdata_o (mem_rdata)
   );

   generate
      if (SHOWAHEAD == int'(FIFO_SHOWAHEAD)) begin : g_showahead
         assign bus.rd_data_o = mem_rdata;
      end else begin : g_normal
         logic [WIDTH-1:0] rd_data_q;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               rd_data_q <= '0;
            end else if (rd_ok) begin
               rd_data_q <= mem_rdata;
            end
         end

         assign bus.rd_data_o = rd_data_q;
      end
   endgenerate

   assign bus.full_o         = full;
   assign bus.empty_o        = empty;
   assign bus.almost_full_o  = (usedw >= AFULL_U);
   assign bus.almost_empty_o = (usedw <= AEMPTY_U);
   assign bus.usedw_o        = usedw;
   assign bus.overflow_o     = overflow;
   assign bus.underflow_o    = underflow;

endmodule

// File: tb/tb_fifo_flags.sv
// Scoreboard bench for fifo_flags: a normal-mode and a show-ahead instance,
// each driven by directed cycles whose post-edge state is queued and checked.
module tb_fifo_flags;

   localparam int AF = 3;
   localparam int AE = 1;

   logic clk_tb = 1'b0;
   logic rst_norm = 1'b0;
   logic rst_sa = 1'b0;

   always #5 clk_tb = ~clk_tb;

   fifo_flags_if #(.WIDTH(4), .DEPTH_BIT(2)) bn ();
   fifo_flags_if #(.WIDTH(4), .DEPTH_BIT(2)) bs ();

   fifo_flags #(
      .WIDTH(4), .DEPTH_BIT(2), .SHOWAHEAD(0), .AFULL_LVL(3), .AEMPTY_LVL(1)
   ) dut_norm (
      .clk_i(clk_tb), .rst_i(rst_norm), .bus(bn)
   );

   fifo_flags #(
      .WIDTH(4), .DEPTH_BIT(2), .SHOWAHEAD(1)
   ) dut_sa (
      .clk_i(clk_tb), .rst_i(rst_sa), .bus(bs)
   );

   typedef struct {
      string      nm;
      bit         cd;
      logic [3:0] d;
      int         u;
      bit         o;
      bit         un;
   } exp_t;

   exp_t q_norm[$];
   exp_t q_sa[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input string what, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s.%s actual=%0h required=%0h", nm, what, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic check_entry(input exp_t e, input logic [3:0] d, input logic [2:0] u,
                              input logic f, input logic em, input logic af,
                              input logic ae, input logic o, input logic un);
      if (e.cd) chk(e.nm, "rd_data", 32'(d), 32'(e.d));
      chk(e.nm, "usedw", 32'(u), 32'(e.u));
      chk(e.nm, "full", 32'(f), 32'(e.u == 4));
      chk(e.nm, "empty", 32'(em), 32'(e.u == 0));
      chk(e.nm, "almost_full", 32'(af), 32'(e.u >= AF));
      chk(e.nm, "almost_empty", 32'(ae), 32'(e.u <= AE));
      chk(e.nm, "overflow", 32'(o), 32'(e.o));
      chk(e.nm, "underflow", 32'(un), 32'(e.un));
   endtask

   // Monitor: one queued expectation per active edge, checked 1 time unit later.
   always begin
      exp_t e;
      @(posedge clk_tb);
      #1;
      if (q_norm.size() > 0) begin
         e = q_norm.pop_front();
         check_entry(e, bn.rd_data_o, bn.usedw_o, bn.full_o, bn.empty_o,
                     bn.almost_full_o, bn.almost_empty_o, bn.overflow_o, bn.underflow_o);
      end
      if (q_sa.size() > 0) begin
         e = q_sa.pop_front();
         check_entry(e, bs.rd_data_o, bs.usedw_o, bs.full_o, bs.empty_o,
                     bs.almost_full_o, bs.almost_empty_o, bs.overflow_o, bs.underflow_o);
      end
   end

   task automatic drive(input bit sa, input string nm, input bit rs, input bit wr,
                        input logic [3:0] wd, input bit rd, input bit cd,
                        input logic [3:0] ed, input int eu, input bit eo, input bit eun);
      exp_t e;
      @(negedge clk_tb);
      rst_norm = 1'b0; bn.wr_req_i = 1'b0; bn.rd_req_i = 1'b0; bn.wr_data_i = '0;
      rst_sa   = 1'b0; bs.wr_req_i = 1'b0; bs.rd_req_i = 1'b0; bs.wr_data_i = '0;
      e.nm = nm; e.cd = cd; e.d = ed; e.u = eu; e.o = eo; e.un = eun;
      if (sa) begin
         rst_sa = rs; bs.wr_req_i = wr; bs.wr_data_i = wd; bs.rd_req_i = rd;
         q_sa.push_back(e);
      end else begin
         rst_norm = rs; bn.wr_req_i = wr; bn.wr_data_i = wd; bn.rd_req_i = rd;
         q_norm.push_back(e);
      end
   endtask

   initial begin
      bn.wr_req_i = 1'b0; bn.rd_req_i = 1'b0; bn.wr_data_i = '0;
      bs.wr_req_i = 1'b0; bs.rd_req_i = 1'b0; bs.wr_data_i = '0;

      // args: sa, name, rst, wr, wdata, rd, check_data, exp_data, exp_usedw, exp_ovf, exp_unf
      drive(0, "n_reset",  1, 1, 4'h9, 1, 1, 4'h0, 0, 0, 0);
      // write 1,2,3 / idle / read x3
      drive(0, "t1_w1",    0, 1, 4'h1, 0, 1, 4'h0, 1, 0, 0);
      drive(0, "t1_w2",    0, 1, 4'h2, 0, 1, 4'h0, 2, 0, 0);
      drive(0, "t1_w3",    0, 1, 4'h3, 0, 1, 4'h0, 3, 0, 0);
      drive(0, "t1_idle",  0, 0, 4'h0, 0, 1, 4'h0, 3, 0, 0);
      drive(0, "t1_r1",    0, 0, 4'h0, 1, 1, 4'h1, 2, 0, 0);
      drive(0, "t1_r2",    0, 0, 4'h0, 1, 1, 4'h2, 1, 0, 0);
      drive(0, "t1_r3",    0, 0, 4'h0, 1, 1, 4'h3, 0, 0, 0);
      // fill, two rejected writes back-to-back, drain
      drive(0, "t2_w1",    0, 1, 4'h1, 0, 1, 4'h3, 1, 0, 0);
      drive(0, "t2_w2",    0, 1, 4'h2, 0, 1, 4'h3, 2, 0, 0);
      drive(0, "t2_w3",    0, 1, 4'h3, 0, 1, 4'h3, 3, 0, 0);
      drive(0, "t2_w4",    0, 1, 4'h4, 0, 1, 4'h3, 4, 0, 0);
      drive(0, "t2_wF",    0, 1, 4'hF, 0, 1, 4'h3, 4, 1, 0);
      drive(0, "t2_wE",    0, 1, 4'hE, 0, 1, 4'h3, 4, 1, 0);
      drive(0, "t2_idle",  0, 0, 4'h0, 0, 1, 4'h3, 4, 0, 0);
      drive(0, "t2_r1",    0, 0, 4'h0, 1, 1, 4'h1, 3, 0, 0);
      drive(0, "t2_r2",    0, 0, 4'h0, 1, 1, 4'h2, 2, 0, 0);
      drive(0, "t2_r3",    0, 0, 4'h0, 1, 1, 4'h3, 1, 0, 0);
      drive(0, "t2_r4",    0, 0, 4'h0, 1, 1, 4'h4, 0, 0, 0);
      // simultaneous read/write at full, drain across pointer wrap
      drive(0, "t3_w1",    0, 1, 4'h1, 0, 1, 4'h4, 1, 0, 0);
      drive(0, "t3_w2",    0, 1, 4'h2, 0, 1, 4'h4, 2, 0, 0);
      drive(0, "t3_w3",    0, 1, 4'h3, 0, 1, 4'h4, 3, 0, 0);
      drive(0, "t3_w4",    0, 1, 4'h4, 0, 1, 4'h4, 4, 0, 0);
      drive(0, "t3_w5rd",  0, 1, 4'h5, 1, 1, 4'h1, 4, 0, 0);
      drive(0, "t3_r2",    0, 0, 4'h0, 1, 1, 4'h2, 3, 0, 0);
      drive(0, "t3_r3",    0, 0, 4'h0, 1, 1, 4'h3, 2, 0, 0);
      drive(0, "t3_r4",    0, 0, 4'h0, 1, 1, 4'h4, 1, 0, 0);
      drive(0, "t3_r5",    0, 0, 4'h0, 1, 1, 4'h5, 0, 0, 0);
      // simultaneous read/write at empty, lone read at empty
      drive(0, "t4_w7rd",  0, 1, 4'h7, 1, 1, 4'h5, 1, 0, 1);
      drive(0, "t4_r7",    0, 0, 4'h0, 1, 1, 4'h7, 0, 0, 0);
      drive(0, "t4_rempty",0, 0, 4'h0, 1, 1, 4'h7, 0, 0, 1);
      drive(0, "t4_idle",  0, 0, 4'h0, 0, 1, 4'h7, 0, 0, 0);
      // threshold walk up and down
      drive(0, "t5_w8",    0, 1, 4'h8, 0, 1, 4'h7, 1, 0, 0);
      drive(0, "t5_w9",    0, 1, 4'h9, 0, 1, 4'h7, 2, 0, 0);
      drive(0, "t5_wA",    0, 1, 4'hA, 0, 1, 4'h7, 3, 0, 0);
      drive(0, "t5_wB",    0, 1, 4'hB, 0, 1, 4'h7, 4, 0, 0);
      drive(0, "t5_r8",    0, 0, 4'h0, 1, 1, 4'h8, 3, 0, 0);
      drive(0, "t5_r9",    0, 0, 4'h0, 1, 1, 4'h9, 2, 0, 0);
      drive(0, "t5_rA",    0, 0, 4'h0, 1, 1, 4'hA, 1, 0, 0);
      drive(0, "t5_rB",    0, 0, 4'h0, 1, 1, 4'hB, 0, 0, 0);
      // reset mid-stream with requests in the reset cycle
      drive(0, "t6_w1",    0, 1, 4'h1, 0, 1, 4'hB, 1, 0, 0);
      drive(0, "t6_w2",    0, 1, 4'h2, 0, 1, 4'hB, 2, 0, 0);
      drive(0, "t6_rst",   1, 1, 4'h3, 1, 1, 4'h0, 0, 0, 0);
      drive(0, "t6_idle",  0, 0, 4'h0, 0, 1, 4'h0, 0, 0, 0);

      // show-ahead instance
      drive(1, "s_reset",  1, 1, 4'h9, 1, 0, 4'h0, 0, 0, 0);
      drive(1, "s_idle",   0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
      drive(1, "s_wA",     0, 1, 4'hA, 0, 1, 4'hA, 1, 0, 0);
      drive(1, "s_wB",     0, 1, 4'hB, 0, 1, 4'hA, 2, 0, 0);
      drive(1, "s_hold",   0, 0, 4'h0, 0, 1, 4'hA, 2, 0, 0);
      drive(1, "s_rA",     0, 0, 4'h0, 1, 1, 4'hB, 1, 0, 0);
      drive(1, "s_wC",     0, 1, 4'hC, 0, 1, 4'hB, 2, 0, 0);
      drive(1, "s_rst",    1, 1, 4'h5, 1, 0, 4'h0, 0, 0, 0);
      drive(1, "s_postrst",0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
      drive(1, "s_wD",     0, 1, 4'hD, 0, 1, 4'hD, 1, 0, 0);
      drive(1, "s_rDwE",   0, 1, 4'hE, 1, 1, 4'hE, 1, 0, 0);
      drive(1, "s_rE",     0, 0, 4'h0, 1, 0, 4'h0, 0, 0, 0);
      drive(1, "s_rempty", 0, 0, 4'h0, 1, 0, 4'h0, 0, 0, 1);
      drive(1, "s_idle2",  0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0);

      @(negedge clk_tb);
      rst_sa = 1'b0; bs.wr_req_i = 1'b0; bs.rd_req_i = 1'b0;
      repeat (3) @(negedge clk_tb);
      n_checks++;
      if (q_norm.size() + q_sa.size() != 0) begin
         $display("FAIL scoreboard_drain actual=%0d required=0", q_norm.size() + q_sa.size());
      end else begin
         n_pass++;
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
